// File: rtl/button_event.sv
// Two-channel button event generator (press/release/long/repeat) feeding a
// shared event FIFO with a valid/ready consumer handshake and sticky overflow.
module button_event #(
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 250,
  parameter int CNT_W         = 16,
  parameter int DEPTH         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d0,
  input  logic       d1,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_chan,
  output logic [1:0] ev_code,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_DOWN, S_HELD} state_e;

  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] timer_q [2];
  logic [CNT_W-1:0] timer_d [2];
  logic             evt_v   [2];
  logic [1:0]       evt_c   [2];
  logic             lvl     [2];

  logic [2:0]    mem_q [DEPTH];
  logic [2:0]    mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr1;
  logic [CW-1:0] count_q, count_d, space;
  logic          ovf_q, ovf_d;
  logic          pop, acc0, acc1, drop;

  assign lvl[0] = d0;
  assign lvl[1] = d1;

  // Per-channel hold-timer FSMs; release always wins over timer expiry.
  always_comb begin
    for (int unsigned ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      timer_d[ch] = timer_q[ch];
      evt_v[ch]   = 1'b0;
      evt_c[ch]   = EV_PRESS;
      case (state_q[ch])
        S_IDLE: begin
          if (lvl[ch]) begin
            evt_v[ch]   = 1'b1;
            evt_c[ch]   = EV_PRESS;
            timer_d[ch] = '0;
            state_d[ch] = S_DOWN;
          end
        end
        S_DOWN: begin
          if (!lvl[ch]) begin
            evt_v[ch]   = 1'b1;
            evt_c[ch]   = EV_RELEASE;
            state_d[ch] = S_IDLE;
          end else if (timer_q[ch] == CNT_W'(LONG_CYCLES - 1)) begin
            evt_v[ch]   = 1'b1;
            evt_c[ch]   = EV_LONG;
            timer_d[ch] = '0;
            state_d[ch] = S_HELD;
          end else begin
            timer_d[ch] = timer_q[ch] + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!lvl[ch]) begin
            evt_v[ch]   = 1'b1;
            evt_c[ch]   = EV_RELEASE;
            state_d[ch] = S_IDLE;
          end else if (timer_q[ch] == CNT_W'(REPEAT_CYCLES - 1)) begin
            evt_v[ch]   = 1'b1;
            evt_c[ch]   = EV_REPEAT;
            timer_d[ch] = '0;
          end else begin
            timer_d[ch] = timer_q[ch] + CNT_W'(1);
          end
        end
        default: state_d[ch] = S_IDLE;
      endcase
    end
  end

  // Free space counts the same-cycle pop; channel 0 claims space first.
  always_comb begin
    pop      = (count_q != '0) && ev_ready;
    space    = CW'(DEPTH) - count_q + CW'(pop);
    acc0     = evt_v[0] && (space != '0);
    acc1     = evt_v[1] && (space > CW'(acc0));
    drop     = (evt_v[0] && !acc0) || (evt_v[1] && !acc1);
    wr_ptr1  = wr_ptr_q + PW'(acc0);
    mem_d    = mem_q;
    if (acc0) mem_d[wr_ptr_q] = {1'b0, evt_c[0]};
    if (acc1) mem_d[wr_ptr1]  = {1'b1, evt_c[1]};
    wr_ptr_d = wr_ptr1 + PW'(acc1);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q - CW'(pop) + CW'(acc0) + CW'(acc1);
    ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        state_q[ch] <= S_IDLE;
        timer_q[ch] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        timer_q[ch] <= timer_d[ch];
      end
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ev_valid = (count_q != '0);
  assign ev_chan  = ev_valid ? mem_q[rd_ptr_q][2] : 1'b0;
  assign ev_code  = ev_valid ? mem_q[rd_ptr_q][1:0] : 2'd0;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with short timers (LONG=8, REPEAT=4, DEPTH=4).
module tb_button_event;

  logic       clk = 1'b0;
  logic       rst_n, d0, d1, ev_ready, ovf_clr;
  logic       ev_valid, ev_chan, ovf;
  logic [1:0] ev_code;
  int         checks = 0;
  int         failures = 0;

  button_event #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (16),
    .DEPTH        (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d0      (d0),
    .d1      (d1),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_chan (ev_chan),
    .ev_code (ev_code),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input string tag, input logic chan, input logic [1:0] code);
    check({tag, "_v"}, 8'(ev_valid), 8'd1);
    check({tag, "_ch"}, 8'(ev_chan), 8'(chan));
    check({tag, "_cd"}, 8'(ev_code), 8'(code));
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       exp_v;
    logic [1:0] exp_c;
    rst_n = 1'b0; d0 = 1'b0; d1 = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
    #3;
    check("rst_valid", 8'(ev_valid), 8'd0);
    check("rst_chan", 8'(ev_chan), 8'd0);
    check("rst_code", 8'(ev_code), 8'd0);
    check("rst_ovf", 8'(ovf), 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("idle_valid", 8'(ev_valid), 8'd0);

    // Short tap on channel 0, consumer always ready
    ev_ready = 1'b1;
    d0 = 1'b1;
    step();
    check("tap_p_v", 8'(ev_valid), 8'd1);
    check("tap_p_ch", 8'(ev_chan), 8'd0);
    check("tap_p_cd", 8'(ev_code), 8'd0);
    step();
    check("tap_gap1", 8'(ev_valid), 8'd0);
    step();
    check("tap_gap2", 8'(ev_valid), 8'd0);
    d0 = 1'b0;
    step();
    check("tap_r_v", 8'(ev_valid), 8'd1);
    check("tap_r_ch", 8'(ev_chan), 8'd0);
    check("tap_r_cd", 8'(ev_code), 8'd1);
    step();
    check("tap_end", 8'(ev_valid), 8'd0);
    check("tap_ovf", 8'(ovf), 8'd0);

    // Long hold on channel 1: PRESS@0, LONG@8, REPEAT@12/16/20, RELEASE@21
    d1 = 1'b1;
    for (int i = 0; i <= 21; i++) begin
      if (i == 21) d1 = 1'b0;
      step();
      exp_v = (i == 0) || (i == 8) || (i == 12) || (i == 16) || (i == 20) || (i == 21);
      check($sformatf("long_v%0d", i), 8'(ev_valid), 8'(exp_v));
      if (exp_v) begin
        exp_c = (i == 0) ? 2'd0 : (i == 8) ? 2'd2 : (i == 21) ? 2'd1 : 2'd3;
        check($sformatf("long_cd%0d", i), 8'(ev_code), 8'(exp_c));
        check($sformatf("long_ch%0d", i), 8'(ev_chan), 8'd1);
      end
    end
    step();
    check("long_end", 8'(ev_valid), 8'd0);

    // Simultaneous press, consumer stalled
    ev_ready = 1'b0;
    d0 = 1'b1; d1 = 1'b1;
    step();
    pop_expect("sim0", 1'b0, 2'd0);
    pop_expect("sim1", 1'b1, 2'd0);
    check("sim_empty", 8'(ev_valid), 8'd0);

    // Overflow: 5 events into a depth-4 FIFO
    d0 = 1'b0; d1 = 1'b0;
    step();
    d0 = 1'b1;
    step();
    d0 = 1'b0;
    step();
    check("ovf_pre", 8'(ovf), 8'd0);
    d1 = 1'b1;
    step();
    check("ovf_set", 8'(ovf), 8'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", 8'(ovf), 8'd0);
    d1 = 1'b0; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_set_wins", 8'(ovf), 8'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr2", 8'(ovf), 8'd0);

    // Full FIFO with pop and one new push in the same cycle
    check("full_head_ch", 8'(ev_chan), 8'd0);
    check("full_head_cd", 8'(ev_code), 8'd1);
    ev_ready = 1'b1; d0 = 1'b1;
    step();
    ev_ready = 1'b0;
    check("fullpop_ovf", 8'(ovf), 8'd0);
    pop_expect("q0", 1'b1, 2'd1);
    pop_expect("q1", 1'b0, 2'd0);
    pop_expect("q2", 1'b0, 2'd1);
    pop_expect("q3", 1'b0, 2'd0);
    check("q_empty", 8'(ev_valid), 8'd0);

    // Queue 3 events with channel 0 reaching HELD, then reset mid-operation
    d1 = 1'b1;
    step();
    d1 = 1'b0;
    step();
    step();
    step();
    check("held_head_ch", 8'(ev_chan), 8'd1);
    check("held_head_cd", 8'(ev_code), 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 8'(ev_valid), 8'd0);
    check("arst_chan", 8'(ev_chan), 8'd0);
    check("arst_code", 8'(ev_code), 8'd0);
    check("arst_ovf", 8'(ovf), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("post_p_v", 8'(ev_valid), 8'd1);
    check("post_p_ch", 8'(ev_chan), 8'd0);
    check("post_p_cd", 8'(ev_code), 8'd0);
    ev_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("post_v%0d", i), 8'(ev_valid), 8'(i == 8));
      if (i == 8) begin
        check("post_long_cd", 8'(ev_code), 8'd2);
        check("post_long_ch", 8'(ev_chan), 8'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event.md
# button_event

Converts two debounced push-button levels into a stream of discrete button events (press, release, long-press, auto-repeat) and buffers them in a small FIFO with a valid/ready output handshake. It sits downstream of the button debouncer, consuming its clean level outputs, and feeds menu and control logic that cannot poll raw levels. Each channel runs an independent hold-timer state machine, and both channels share one event queue.

## Interface
- LONG_CYCLES, 1000: number of cycles a button must be held after PRESS before LONG is emitted; must be ≥ 2.
- REPEAT_CYCLES, 250: period of REPEAT events after LONG; must be ≥ 2.
- CNT_W, 16: hold-timer width; must hold max(LONG_CYCLES, REPEAT_CYCLES) - 1.
- DEPTH, 4: FIFO depth; power of two, ≥ 2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d0  in  1  debounced level, channel 0; 1 = pressed; synchronous to clk.
- d1  in  1  debounced level, channel 1; same semantics as d0.
- ev_valid  out  1  FIFO non-empty; the head event is presented.
- ev_ready  in  1  consumer accepts the head when ev_valid && ev_ready.
- ev_chan  out  1  head event channel (0/1); forced to 0 when empty.
- ev_code  out  2  head event code: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT; forced to 0 when empty.
- ovf  out  1  sticky flag: at least one event was dropped.
- ovf_clr  in  1  synchronous clear of ovf.

## Operation
- Reset (asynchronous assert) puts both FSMs in IDLE, clears the timers to 0, and empties the FIFO. While reset is asserted: ev_valid=0, ev_chan=0, ev_code=0, ovf=0.
- Each channel has an FSM with states IDLE, DOWN and HELD. Let d be the channel's level input.
  - IDLE: if d=1, emit PRESS, clear the timer, and go to DOWN.
  - DOWN: if d=0, emit RELEASE and go to IDLE. Otherwise, if timer==LONG_CYCLES-1, emit LONG, clear the timer, and go to HELD; else increment the timer.
  - HELD: if d=0, emit RELEASE and go to IDLE. Otherwise, if timer==REPEAT_CYCLES-1, emit REPEAT and clear the timer; else increment the timer.
  - Release takes priority over the timer expiring in the same cycle: RELEASE is emitted and LONG/REPEAT is not.
- FIFO:
  - Each event is pushed as {chan, code}.
  - Up to two pushes are possible per cycle. Channel 0's event is pushed first, then channel 1's.
  - Free space is computed after any same-cycle pop, so a full FIFO with a pop in progress accepts one push.
  - A push that finds no space is dropped and sets ovf. Earlier entries are never overwritten.
- ovf:
  - Set by any drop.
  - ovf_clr clears it.
  - If a drop and ovf_clr occur in the same cycle, ovf ends the cycle set (the set wins).
- The timer arithmetic is unsigned CNT_W bits. The timer never wraps, because it is cleared on every compare match.
- If rst_n is released while d=1, the first active edge sees IDLE with d=1 and emits PRESS. Events that were queued before reset are lost.

## Timing
- Event latency:
  - The FSM samples d at edge k.
  - The event is written to the FIFO at edge k.
  - ev_valid rises after edge k if the FIFO was empty.
  - Total latency is one cycle from d changing before edge k.
- With d rising before edge k and held high:
  - PRESS is emitted at edge k.
  - LONG is emitted at edge k+LONG_CYCLES.
  - REPEAT is emitted at edges k+LONG_CYCLES+n·REPEAT_CYCLES, for n ≥ 1.
- Head outputs are registered or derived from registered state only; there is no combinational path from d0/d1 to ev_*.
- Handshake:
  - The head is held stable while ev_valid && !ev_ready.
  - A pop at edge e exposes the next entry after edge e.
  - A simultaneous push and pop on an empty FIFO is not possible: ev_valid=0, so no pop occurs.
- Throughput: one pop per cycle and up to two pushes per cycle.

## Test plan
- Short tap: with LONG_CYCLES=8 and ev_ready=1, hold d0=1 for 3 cycles -> ev_valid pulses for exactly two events, {0,PRESS} then {0,RELEASE}. No LONG is emitted and ovf=0.
- Long hold with repeat: with LONG_CYCLES=8, REPEAT_CYCLES=4, hold d1=1 for 20 cycles starting at edge k -> PRESS at k, LONG at k+8, REPEAT at k+12, k+16 and k+20, then RELEASE once d1 falls.
- Simultaneous: d0 and d1 rise before the same edge, with an empty FIFO and ev_ready=0 -> the FIFO holds {0,PRESS} then {1,PRESS} in that order, and ev_chan=0 is presented first.
- Overflow: with DEPTH=4 and ev_ready=0, generate 5 events -> the first 4 are retained in order, the 5th is dropped, and ovf=1. Pulsing ovf_clr with no new drop gives ovf=0. A drop coincident with ovf_clr leaves ovf=1.
- Full with pop: with the FIFO full, ev_ready=1, and one new event in the same cycle -> the event is accepted, ovf stays 0, and the occupancy remains 4.
- Reset mid-operation: assert rst_n=0 while in HELD with 3 queued events, and keep d0=1 -> ev_valid=0 immediately (asynchronously). After release, the first event is {0,PRESS}, and LONG follows LONG_CYCLES later.
